// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop framing with 3-sample majority vote.
// Busy is decoded from the state register; P_DATA only updates on error-free frames.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  Par_En,
    input  logic                  Par_Typ,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stop_Err,
    output logic                  Busy
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [5:0]            edge_cnt;
    logic [2:0]            samples;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_en_q, par_typ_q, par_flag;
    logic [5:0]            half, last;
    logic                  bit_end, smp_hit, bit_val, last_data;

    assign half      = Prescale >> 1;
    assign last      = Prescale - 6'd1;
    // '>=' rather than '==' so a mid-frame Prescale change can never strand the counter
    assign bit_end   = (edge_cnt >= last);
    assign smp_hit   = (edge_cnt == half - 6'd1) || (edge_cnt == half) || (edge_cnt == half + 6'd1);
    assign bit_val   = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
    assign last_data = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign Busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!RX_IN) state_nxt = START;
            START:   if (bit_end) state_nxt = bit_val ? IDLE : DATA;
            DATA:    if (bit_end && last_data) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt   <= '0;
            samples    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag   <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;

            if (state == IDLE || bit_end) edge_cnt <= '0;
            else                          edge_cnt <= edge_cnt + 6'd1;

            if (smp_hit) samples <= {samples[1:0], RX_IN};

            case (state)
                IDLE: if (!RX_IN) begin
                    par_en_q  <= Par_En;
                    par_typ_q <= Par_Typ;
                    par_flag  <= 1'b0;
                    bit_cnt   <= '0;
                end
                DATA: if (bit_end) begin
                    shift   <= {bit_val, shift[DATA_WIDTH-1:1]};
                    bit_cnt <= bit_cnt + BW'(1);
                end
                PARITY: if (bit_end) par_flag <= bit_val ^ (^shift) ^ par_typ_q;
                STOP: if (bit_end) begin
                    Stop_Err <= ~bit_val;
                    Par_Err  <= par_flag;
                    if (bit_val && !par_flag) begin
                        P_DATA     <= shift;
                        Data_Valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
